// File: rtl/lpc.sv
// ---------------------------------------------------------------------------
// lpc : passive LPC bus sniffer.
//
// Watches LAD[3:0] / LFRAME# and decodes host-initiated I/O and memory
// cycles, both read and write. Each completed cycle loads one record onto
// the outputs and pulses out_clock_enable for exactly one clock. The block
// only observes the bus and never drives it.
//
// Ports:
//   lpc_clock         in   LPC clock, all sampling on the rising edge
//   lpc_reset         in   asynchronous reset, active low
//   lpc_ad[3:0]       in   LAD[3:0]
//   lpc_frame         in   LFRAME#, active low
//   out_cyctype_dir   out  CT/DIR nibble: [3:2] type, [1] dir (1 = write)
//   out_addr[31:0]    out  captured address (IO zero-extended from 16 bits)
//   out_data[31:0]    out  captured data byte in [7:0]
//   out_data_size     out  bytes transferred (always 1)
//   out_clock_enable  out  one-clock strobe, record valid
//
// Build option:
//   LPC_SYNC_TIMEOUT_EN  when defined, a cycle is abandoned after
//                        SYNC_TIMEOUT consecutive wait-SYNC nibbles.
// ---------------------------------------------------------------------------
module lpc #(
   parameter int unsigned SYNC_TIMEOUT = 16
) (
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic [3:0]  lpc_ad,
   input  logic        lpc_frame,
   output logic [3:0]  out_cyctype_dir,
   output logic [31:0] out_addr,
   output logic [31:0] out_data,
   output logic [3:0]  out_data_size,
   output logic        out_clock_enable
);

   localparam int unsigned CNT_W    = $clog2(SYNC_TIMEOUT + 1);
   localparam int unsigned IO_NIBS  = 4;
   localparam int unsigned MEM_NIBS = 8;

   localparam logic [3:0] AD_START      = 4'b0000;
   localparam logic [3:0] SYNC_READY    = 4'b0000;
   localparam logic [3:0] SYNC_SHORT_WT = 4'b0101;
   localparam logic [3:0] SYNC_LONG_WT  = 4'b0110;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CTDIR,
      ST_ADDR,
      ST_WDATA,
      ST_TAR1,
      ST_SYNC,
      ST_RDATA,
      ST_TAR2
   } state_t;

   state_t           state;
   logic [3:0]       ctdir;
   logic [31:0]      addr;
   logic [7:0]       data;
   logic [2:0]       nib_cnt;   // address nibbles still to come, minus one
   logic             phase;     // second half of a two-nibble phase
   logic [CNT_W-1:0] sync_cnt;  // consecutive wait-SYNC nibbles seen

   // Cycle decoder and registered record outputs.
   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         state            <= ST_IDLE;
         ctdir            <= '0;
         addr             <= '0;
         data             <= '0;
         nib_cnt          <= '0;
         phase            <= 1'b0;
         sync_cnt         <= '0;
         out_cyctype_dir  <= '0;
         out_addr         <= '0;
         out_data         <= '0;
         out_data_size    <= '0;
         out_clock_enable <= 1'b0;
      end else begin
         out_clock_enable <= 1'b0;

         if (!lpc_frame) begin
            // LFRAME# low always restarts decoding; any partial cycle is
            // dropped. The last low cycle carrying 0000 is the real START.
            phase    <= 1'b0;
            sync_cnt <= '0;
            if (lpc_ad == AD_START) begin
               state <= ST_CTDIR;
               addr  <= '0;
            end else begin
               state <= ST_IDLE;
            end
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_IDLE;
               end

               ST_CTDIR: begin
                  ctdir <= {lpc_ad[3:1], 1'b0};
                  if (lpc_ad[3:2] == 2'b00) begin
                     nib_cnt <= 3'(IO_NIBS - 1);
                     state   <= ST_ADDR;
                  end else if (lpc_ad[3:2] == 2'b01) begin
                     nib_cnt <= 3'(MEM_NIBS - 1);
                     state   <= ST_ADDR;
                  end else begin
                     // DMA, reserved or unknown content: not decoded.
                     state <= ST_IDLE;
                  end
               end

               ST_ADDR: begin
                  addr <= {addr[27:0], lpc_ad};
                  if (nib_cnt == 3'd0) begin
                     phase <= 1'b0;
                     state <= ctdir[1] ? ST_WDATA : ST_TAR1;
                  end else begin
                     nib_cnt <= nib_cnt - 3'd1;
                  end
               end

               ST_WDATA: begin
                  if (!phase) begin
                     data[3:0] <= lpc_ad;
                     phase     <= 1'b1;
                  end else begin
                     data[7:4] <= lpc_ad;
                     phase     <= 1'b0;
                     state     <= ST_TAR1;
                  end
               end

               ST_TAR1: begin
                  if (!phase) begin
                     phase <= 1'b1;
                  end else begin
                     phase    <= 1'b0;
                     sync_cnt <= '0;
                     state    <= ST_SYNC;
                  end
               end

               ST_SYNC: begin
                  case (lpc_ad)
                     SYNC_READY: begin
                        phase <= 1'b0;
                        if (ctdir[1]) begin
                           // Write data is already held: publish now.
                           out_cyctype_dir  <= ctdir;
                           out_addr         <= addr;
                           out_data         <= {24'h0, data};
                           out_data_size    <= 4'd1;
                           out_clock_enable <= 1'b1;
                           state            <= ST_TAR2;
                        end else begin
                           state <= ST_RDATA;
                        end
                     end
                     SYNC_SHORT_WT, SYNC_LONG_WT: begin
`ifdef LPC_SYNC_TIMEOUT_EN
                        if (32'(sync_cnt) + 32'd1 >= 32'(SYNC_TIMEOUT)) begin
                           state <= ST_IDLE;
                        end else begin
                           sync_cnt <= sync_cnt + CNT_W'(1);
                        end
`else
                        // Wait indefinitely; the count only saturates.
                        if (32'(sync_cnt) < 32'(SYNC_TIMEOUT)) begin
                           sync_cnt <= sync_cnt + CNT_W'(1);
                        end
`endif
                     end
                     default: begin
                        // Error (1010) or an invalid SYNC code.
                        state <= ST_IDLE;
                     end
                  endcase
               end

               ST_RDATA: begin
                  if (!phase) begin
                     data[3:0] <= lpc_ad;
                     phase     <= 1'b1;
                  end else begin
                     data[7:4]        <= lpc_ad;
                     phase            <= 1'b0;
                     out_cyctype_dir  <= ctdir;
                     out_addr         <= addr;
                     out_data         <= {24'h0, lpc_ad, data[3:0]};
                     out_data_size    <= 4'd1;
                     out_clock_enable <= 1'b1;
                     state            <= ST_TAR2;
                  end
               end

               ST_TAR2: begin
                  if (!phase) begin
                     phase <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     state <= ST_IDLE;
                  end
               end

               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lpc.sv
// ---------------------------------------------------------------------------
// tb_lpc : self-checking bench for the lpc sniffer.
// Expected records are queued as each bus cycle is driven; records seen on
// the strobe are collected by a monitor and compared per scenario.
// ---------------------------------------------------------------------------
module tb_lpc;

   logic        lpc_clock;
   logic        lpc_reset;
   logic [3:0]  lpc_ad;
   logic        lpc_frame;
   logic [3:0]  out_cyctype_dir;
   logic [31:0] out_addr;
   logic [31:0] out_data;
   logic [3:0]  out_data_size;
   logic        out_clock_enable;

   int n_cmp = 0;
   int n_err = 0;

   logic [71:0] exp_q[$];
   logic [71:0] got_q[$];

   lpc #(.SYNC_TIMEOUT(16)) dut (
      .lpc_clock        (lpc_clock),
      .lpc_reset        (lpc_reset),
      .lpc_ad           (lpc_ad),
      .lpc_frame        (lpc_frame),
      .out_cyctype_dir  (out_cyctype_dir),
      .out_addr         (out_addr),
      .out_data         (out_data),
      .out_data_size    (out_data_size),
      .out_clock_enable (out_clock_enable)
   );

   initial lpc_clock = 1'b0;
   always #5 lpc_clock = ~lpc_clock;

   // Collect every strobed record, sampled on the falling edge.
   always @(negedge lpc_clock) begin
      if (lpc_reset && out_clock_enable)
         got_q.push_back({out_cyctype_dir, out_addr, out_data, out_data_size});
   end

   function automatic logic [71:0] rec(input logic [3:0] ct, input logic [31:0] a,
                                       input logic [7:0] d);
      return {ct, a, {24'h0, d}, 4'd1};
   endfunction

   task automatic send(input logic f, input logic [3:0] a);
      lpc_frame = f;
      lpc_ad    = a;
      @(negedge lpc_clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(1'b1, 4'hf);
   endtask

   // Drive one host cycle; nstart low-frame cycles, the last one being START.
   task automatic do_cycle(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d,
                           input int nwait, input logic [3:0] wnib,
                           input logic [3:0] sync_end, input int nstart, input int ntar_end);
      int nn;
      nn = ct[2] ? 8 : 4;
      for (int i = 0; i < nstart - 1; i++) send(1'b0, 4'hf);
      send(1'b0, 4'h0);
      send(1'b1, ct);
      for (int i = 0; i < nn; i++) send(1'b1, a[4*(nn-1-i) +: 4]);
      if (ct[1]) begin
         send(1'b1, d[3:0]);
         send(1'b1, d[7:4]);
      end
      send(1'b1, 4'hf);
      send(1'b1, 4'hf);
      for (int i = 0; i < nwait; i++) send(1'b1, wnib);
      send(1'b1, sync_end);
      if (!ct[1]) begin
         send(1'b1, d[3:0]);
         send(1'b1, d[7:4]);
      end
      for (int i = 0; i < ntar_end; i++) send(1'b1, 4'hf);
   endtask

   task automatic test_reset();
      lpc_reset = 1'b0;
      lpc_frame = 1'b1;
      lpc_ad    = 4'hf;
      repeat (3) @(negedge lpc_clock);
      n_cmp++;
      if ({out_cyctype_dir, out_addr, out_data, out_data_size, out_clock_enable} !== 73'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want 0",
                  {out_cyctype_dir, out_addr, out_data, out_data_size, out_clock_enable});
      end
      lpc_reset = 1'b1;
      idle(3);
      n_cmp++;
      if (out_clock_enable !== 1'b0 || out_addr !== 32'h0) begin
         n_err++;
         $display("FAIL reset_release: strobe %b addr %h want 0/0", out_clock_enable, out_addr);
      end
   endtask

   task automatic test_io_read();
      exp_q.push_back(rec(4'h0, 32'h0000_7fe5, 8'h6c));
      do_cycle(4'h0, 32'h7fe5, 8'h6c, 3, 4'h5, 4'h0, 1, 2);
      idle(3);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL io_read_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [71:0] e, g;
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL io_read_rec: got %h want %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_io_write();
      exp_q.push_back(rec(4'h2, 32'h0000_0080, 8'h5a));
      do_cycle(4'h2, 32'h0080, 8'h5a, 0, 4'h5, 4'h0, 1, 2);
      idle(3);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL io_write_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [71:0] e, g;
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL io_write_rec: got %h want %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_mem_read();
      // Also holds LFRAME# low for three cycles before the real START.
      exp_q.push_back(rec(4'h4, 32'hffff_ffd0, 8'h12));
      do_cycle(4'h4, 32'hffff_ffd0, 8'h12, 5, 4'h6, 4'h0, 3, 2);
      idle(3);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL mem_read_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [71:0] e, g;
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL mem_read_rec: got %h want %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_abort_and_dma();
      // Partial IO read cut off after two address nibbles.
      send(1'b0, 4'h0);
      send(1'b1, 4'h0);
      send(1'b1, 4'h1);
      send(1'b1, 4'h2);
      exp_q.push_back(rec(4'h0, 32'h0000_002e, 8'h11));
      do_cycle(4'h0, 32'h002e, 8'h11, 1, 4'h5, 4'h0, 1, 2);
      idle(2);
      // DMA CT/DIR is not decoded and must not strobe.
      do_cycle(4'h8, 32'h1234, 8'h99, 0, 4'h5, 4'h0, 1, 2);
      idle(3);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL abort_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [71:0] e, g;
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL abort_rec: got %h want %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_sync_error();
      do_cycle(4'h0, 32'h0060, 8'hab, 2, 4'h5, 4'ha, 1, 2);
      idle(3);
      n_cmp++;
      if (got_q.size() != 0) begin
         n_err++;
         $display("FAIL sync_err_count: got %0d want 0", got_q.size());
      end
      n_cmp++;
      if (out_addr !== 32'h0000_002e || out_data !== 32'h0000_0011) begin
         n_err++;
         $display("FAIL sync_err_hold: got %h/%h want 0000002e/00000011", out_addr, out_data);
      end
      got_q.delete();
      exp_q.push_back(rec(4'h2, 32'h0000_0061, 8'hc3));
      do_cycle(4'h2, 32'h0061, 8'hc3, 0, 4'h5, 4'h0, 1, 2);
      idle(3);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL sync_err_next_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [71:0] e, g;
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL sync_err_next_rec: got %h want %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_back_to_back();
      // Second START lands right after final TAR; third START cuts the
      // second read's final TAR short, which is allowed.
      exp_q.push_back(rec(4'h0, 32'h0000_0070, 8'h01));
      exp_q.push_back(rec(4'h4, 32'h000f_0000, 8'hfe));
      exp_q.push_back(rec(4'h6, 32'h8000_0001, 8'h3c));
      do_cycle(4'h0, 32'h0070, 8'h01, 0, 4'h5, 4'h0, 1, 2);
      do_cycle(4'h4, 32'h000f_0000, 8'hfe, 2, 4'h6, 4'h0, 1, 1);
      do_cycle(4'h6, 32'h8000_0001, 8'h3c, 1, 4'h5, 4'h0, 1, 2);
      idle(3);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [71:0] e, g;
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL b2b_rec: got %h want %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_sync_timeout();
      // Twenty long waits: abandoned when the timeout is built in,
      // otherwise the ready SYNC completes the read.
`ifndef LPC_SYNC_TIMEOUT_EN
      exp_q.push_back(rec(4'h0, 32'h0000_03f8, 8'h77));
`endif
      do_cycle(4'h0, 32'h03f8, 8'h77, 20, 4'h6, 4'h0, 1, 2);
      idle(3);
      n_cmp++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL timeout_count: got %0d want %0d", got_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         logic [71:0] e, g;
         e = exp_q.pop_front(); g = got_q.pop_front();
         n_cmp++;
         if (g !== e) begin n_err++; $display("FAIL timeout_rec: got %h want %h", g, e); end
      end
      exp_q.delete(); got_q.delete();
   endtask

   task automatic test_reset_mid_addr();
      send(1'b0, 4'h0);
      send(1'b1, 4'h2);
      send(1'b1, 4'h1);
      send(1'b1, 4'h2);
      lpc_reset = 1'b0;
      #1;
      n_cmp++;
      if ({out_cyctype_dir, out_addr, out_data, out_data_size, out_clock_enable} !== 73'h0) begin
         n_err++;
         $display("FAIL reset_mid_addr: got %h want 0",
                  {out_cyctype_dir, out_addr, out_data, out_data_size, out_clock_enable});
      end
      @(negedge lpc_clock);
      lpc_reset = 1'b1;
      // Remainder of the interrupted cycle must be ignored.
      send(1'b1, 4'h3);
      send(1'b1, 4'h4);
      idle(8);
      n_cmp++;
      if (got_q.size() != 0) begin
         n_err++;
         $display("FAIL reset_mid_addr_count: got %0d want 0", got_q.size());
      end
      got_q.delete();
   endtask

   initial begin
      test_reset();
      test_io_read();
      test_io_write();
      test_mem_read();
      test_abort_and_dma();
      test_sync_error();
      test_back_to_back();
      test_sync_timeout();
      test_reset_mid_addr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
